shootout_sequencer: RTL and testbench

Referee controller for the penalty-shootout game. It latches the game mode (5-kick or 3-kick series) and alternates the shooter between team A and team B. It grants each kick to the game datapath, collects each kick result, and applies early-termination and sudden-death rules. It sits between the debounced button inputs and the goalkeeper/forward datapath, and drives the scoreboard and the end-of-game indication.

---
 rtl/shootout_pkg.sv | 29 ++
 rtl/shootout_eval.sv | 58 +++++
 rtl/shootout_sequencer.sv | 148 ++++++++++++++
 tb/tb_shootout_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shootout_pkg.sv
// rtl/shootout_pkg.sv - shared types and constants for the penalty-shootout referee
package shootout_pkg;

  localparam int DEF_ROUNDS_LONG  = 5;
  localparam int DEF_ROUNDS_SHORT = 3;
  localparam int DEF_CNT_W        = 3;

  localparam logic TEAM_A = 1'b0;
  localparam logic TEAM_B = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM_A,
    S_WAIT_A,
    S_ARM_B,
    S_WAIT_B,
    S_DONE
  } state_t;

  // Winner code for the team that scored the deciding kick.
  function automatic logic [1:0] team_winner(input logic team);
    return (team == TEAM_B) ? WIN_B : WIN_A;
  endfunction

endpackage

// File: rtl/shootout_eval.sv
// rtl/shootout_eval.sv - combinational end-of-game evaluation after each kick result
module shootout_eval
  import shootout_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic [CNT_W-1:0] score_a,
  input  logic [CNT_W-1:0] score_b,
  input  logic [CNT_W-1:0] k_a,
  input  logic [CNT_W-1:0] k_b,
  input  logic [CNT_W-1:0] n_rounds,
  input  logic             sudden,
  input  logic             shooter,
  input  logic             goal_a,
  input  logic             goal,
  output logic             finish,
  output logic [1:0]       winner,
  output logic             enter_sudden
);

  // Inputs are the post-update scores and kick counts of the current result.
  logic [CNT_W:0] rem_a;
  logic [CNT_W:0] rem_b;
  logic           lead_a;
  logic           lead_b;
  logic           tied;

  // Remaining regulation kicks per team and the unreachable-lead tests.
  always_comb begin
    rem_a  = (k_a >= n_rounds) ? '0 : ({1'b0, n_rounds} - {1'b0, k_a});
    rem_b  = (k_b >= n_rounds) ? '0 : ({1'b0, n_rounds} - {1'b0, k_b});
    lead_a = {1'b0, score_a} > ({1'b0, score_b} + rem_b);
    lead_b = {1'b0, score_b} > ({1'b0, score_a} + rem_a);
    tied   = (score_a == score_b);
  end

  // Regulation uses the scores; sudden death only compares the round's two kicks.
  always_comb begin
    finish       = 1'b0;
    winner       = WIN_NONE;
    enter_sudden = 1'b0;
    if (!sudden) begin
      if (lead_a) begin
        finish = 1'b1;
        winner = WIN_A;
      end else if (lead_b) begin
        finish = 1'b1;
        winner = WIN_B;
      end else if (shooter == TEAM_B && k_b >= n_rounds && tied) begin
        enter_sudden = 1'b1;
      end
    end else if (shooter == TEAM_B && goal_a != goal) begin
      finish = 1'b1;
      winner = goal_a ? team_winner(TEAM_A) : team_winner(TEAM_B);
    end
  end

endmodule

// File: rtl/shootout_sequencer.sv
// rtl/shootout_sequencer.sv - penalty-shootout referee FSM with scoreboard and sudden death
module shootout_sequencer
  import shootout_pkg::*;
#(
  parameter int ROUNDS_LONG  = DEF_ROUNDS_LONG,
  parameter int ROUNDS_SHORT = DEF_ROUNDS_SHORT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode_long,
  input  logic             mode_short,
  input  logic             kick,
  input  logic             result_valid,
  input  logic             goal,
  output logic             kick_en,
  output logic             turn,
  output logic [CNT_W-1:0] score_a,
  output logic [CNT_W-1:0] score_b,
  output logic [CNT_W-1:0] round,
  output logic             sudden,
  output logic             done,
  output logic [1:0]       winner
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] N_LONG  = CNT_W'(ROUNDS_LONG);
  localparam logic [CNT_W-1:0] N_SHORT = CNT_W'(ROUNDS_SHORT);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] n_rounds;
  logic [CNT_W-1:0] k_a;
  logic [CNT_W-1:0] k_b;
  logic             goal_a;

  logic             start;
  logic             a_res;
  logic             b_res;
  logic [CNT_W-1:0] score_a_nx;
  logic [CNT_W-1:0] score_b_nx;
  logic [CNT_W-1:0] k_a_nx;
  logic [CNT_W-1:0] k_b_nx;
  logic [CNT_W-1:0] round_nx;
  logic             finish;
  logic [1:0]       win_eval;
  logic             enter_sudden;

  // Qualified events and saturating next values fed to the evaluator.
  always_comb begin
    start      = (state == S_IDLE || state == S_DONE) && (mode_long || mode_short);
    a_res      = (state == S_WAIT_A) && result_valid;
    b_res      = (state == S_WAIT_B) && result_valid;
    score_a_nx = (a_res && goal && score_a != '1) ? score_a + ONE : score_a;
    score_b_nx = (b_res && goal && score_b != '1) ? score_b + ONE : score_b;
    k_a_nx     = (a_res && k_a != '1) ? k_a + ONE : k_a;
    k_b_nx     = (b_res && k_b != '1) ? k_b + ONE : k_b;
    round_nx   = (round != '1) ? round + ONE : round;
  end

  shootout_eval #(
    .CNT_W(CNT_W)
  ) u_eval (
    .score_a     (score_a_nx),
    .score_b     (score_b_nx),
    .k_a         (k_a_nx),
    .k_b         (k_b_nx),
    .n_rounds    (n_rounds),
    .sudden      (sudden),
    .shooter     (state == S_WAIT_B),
    .goal_a      (goal_a),
    .goal        (goal),
    .finish      (finish),
    .winner      (win_eval),
    .enter_sudden(enter_sudden)
  );

  // State register; en low freezes the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (en) begin
      state <= state_nx;
    end
  end

  // Next-state logic: mode starts a game, kick arms a wait, result advances or ends.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (mode_long || mode_short) state_nx = S_ARM_A;
      S_ARM_A:        if (kick) state_nx = S_WAIT_A;
      S_WAIT_A:       if (result_valid) state_nx = finish ? S_DONE : S_ARM_B;
      S_ARM_B:        if (kick) state_nx = S_WAIT_B;
      S_WAIT_B:       if (result_valid) state_nx = finish ? S_DONE : S_ARM_A;
      default:        state_nx = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    kick_en = (state == S_ARM_A) || (state == S_ARM_B);
    turn    = (state == S_ARM_B) || (state == S_WAIT_B);
    done    = (state == S_DONE);
  end

  // Score, kick, round and phase bookkeeping; a game start clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_rounds <= N_LONG;
      score_a  <= '0;
      score_b  <= '0;
      k_a      <= '0;
      k_b      <= '0;
      round    <= '0;
      sudden   <= 1'b0;
      goal_a   <= 1'b0;
      winner   <= WIN_NONE;
    end else if (en) begin
      if (start) begin
        n_rounds <= mode_long ? N_LONG : N_SHORT;
        score_a  <= '0;
        score_b  <= '0;
        k_a      <= '0;
        k_b      <= '0;
        round    <= '0;
        sudden   <= 1'b0;
        goal_a   <= 1'b0;
        winner   <= WIN_NONE;
      end else begin
        if (a_res) begin
          score_a <= score_a_nx;
          k_a     <= k_a_nx;
          goal_a  <= goal;
        end
        if (b_res) begin
          score_b <= score_b_nx;
          k_b     <= k_b_nx;
          round   <= round_nx;
          if (enter_sudden) sudden <= 1'b1;
        end
        if ((a_res || b_res) && finish) winner <= win_eval;
      end
    end
  end

endmodule

// File: tb/tb_shootout_sequencer.sv
// tb/tb_shootout_sequencer.sv - scoreboard bench for the penalty-shootout referee
module tb_shootout_sequencer;

  localparam int SAT = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b1;
  logic       mode_long = 1'b0;
  logic       mode_short = 1'b0;
  logic       kick = 1'b0;
  logic       result_valid = 1'b0;
  logic       goal = 1'b0;
  logic       rv_tag = 1'b0;
  logic       kick_en;
  logic       turn;
  logic [2:0] score_a;
  logic [2:0] score_b;
  logic [2:0] round;
  logic       sudden;
  logic       done;
  logic [1:0] winner;

  shootout_sequencer #(
    .ROUNDS_LONG (5),
    .ROUNDS_SHORT(3),
    .CNT_W       (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .mode_long   (mode_long),
    .mode_short  (mode_short),
    .kick        (kick),
    .result_valid(result_valid),
    .goal        (goal),
    .kick_en     (kick_en),
    .turn        (turn),
    .score_a     (score_a),
    .score_b     (score_b),
    .round       (round),
    .sudden      (sudden),
    .done        (done),
    .winner      (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sa;
    int sb;
    int rnd;
    int sud;
    int dn;
    int win;
    int trn;
    int ken;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;

  int   m_n, m_ga, m_gb, m_ka, m_kb, m_win, m_turn, m_sd_rounds;
  bit   m_sudden, m_done, m_last_a;

  bit   s_long[$];
  bit   s_short[$];
  bit   s_sudden[$];
  bit   s_none[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Scoreboard monitor: each scored result strobe pops one expected snapshot.
  always @(posedge clk) begin
    if (rv_tag && en && rst) begin
      #1;
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got empty queue expected an entry");
      end else begin
        mon_e = sbq.pop_front();
        chk("score_a", score_a, mon_e.sa);
        chk("score_b", score_b, mon_e.sb);
        chk("round", round, mon_e.rnd);
        chk("sudden", sudden, mon_e.sud);
        chk("done", done, mon_e.dn);
        chk("winner", winner, mon_e.win);
        chk("kick_en", kick_en, mon_e.ken);
        if (mon_e.dn == 0) chk("turn", turn, mon_e.trn);
      end
    end
  end

  task automatic model_start(input int n);
    m_n = n; m_ga = 0; m_gb = 0; m_ka = 0; m_kb = 0;
    m_win = 0; m_turn = 0; m_sd_rounds = 0;
    m_sudden = 0; m_done = 0; m_last_a = 0;
  endtask

  // Reference rules: a lead that the trailing team can no longer close ends the
  // game; a tie after regulation enters sudden death decided per round.
  task automatic model_result(input int team, input bit g);
    exp_t e;
    if (team == 0) begin
      m_ka++;
      if (g) m_ga++;
      m_last_a = g;
    end else begin
      m_kb++;
      if (g) m_gb++;
    end
    if (!m_sudden) begin
      if (m_ga > m_gb + (m_n - m_kb)) begin
        m_done = 1; m_win = 1;
      end else if (m_gb > m_ga + (m_n - m_ka)) begin
        m_done = 1; m_win = 2;
      end else if (team == 1 && m_kb == m_n && m_ga == m_gb) begin
        m_sudden = 1;
      end
    end else if (team == 1) begin
      m_sd_rounds++;
      if (m_last_a != g) begin
        m_done = 1;
        m_win = m_last_a ? 1 : 2;
      end
    end
    m_turn = (team == 0) ? 1 : 0;
    e.sa = sat(m_ga); e.sb = sat(m_gb); e.rnd = sat(m_kb);
    e.sud = m_sudden; e.dn = m_done; e.win = m_win;
    e.trn = m_turn; e.ken = m_done ? 0 : 1;
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input int team);
    for (int i = 0; i < 50 && !kick_en; i++) @(negedge clk);
    chk("grant", kick_en, 1);
    chk("grant_turn", turn, team);
  endtask

  task automatic start_game(input bit lng, input bit both);
    mode_long = lng | both;
    mode_short = !lng | both;
    @(negedge clk);
    mode_long = 0;
    mode_short = 0;
    model_start((lng || both) ? 5 : 3);
    chk("start_kick_en", kick_en, 1);
    chk("start_turn", turn, 0);
    chk("start_score_a", score_a, 0);
    chk("start_score_b", score_b, 0);
    chk("start_round", round, 0);
    chk("start_sudden", sudden, 0);
    chk("start_done", done, 0);
    chk("start_winner", winner, 0);
  endtask

  task automatic do_kick(input int team, input bit g, input bit noise);
    wait_grant(team);
    if (noise) begin
      if (team == 1) begin
        result_valid = 1; goal = 1;
      end else begin
        mode_long = (m_n == 3); mode_short = (m_n == 5);
      end
      @(negedge clk);
      result_valid = 0; goal = 0; mode_long = 0; mode_short = 0;
      chk("noise_arm_score_a", score_a, sat(m_ga));
      chk("noise_arm_score_b", score_b, sat(m_gb));
      chk("noise_arm_grant", kick_en, 1);
    end
    kick = 1;
    @(negedge clk);
    kick = 0;
    chk("kick_taken", kick_en, 0);
    if (noise) begin
      kick = 1; mode_short = 1;
      @(negedge clk);
      kick = 0; mode_short = 0;
      chk("noise_wait_hold", kick_en, 0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    result_valid = 1; goal = g; rv_tag = 1; kick = noise;
    model_result(team, g);
    @(negedge clk);
    result_valid = 0; goal = 0; rv_tag = 0; kick = 0;
  endtask

  task automatic play(input bit script[$], input int noise_pct);
    int idx = 0;
    int guard = 0;
    int team;
    bit g;
    while (!m_done && guard < 100) begin
      team = m_turn;
      if (idx < script.size()) begin
        g = script[idx];
        idx++;
      end else begin
        g = 1'($urandom_range(0, 1));
      end
      if (m_sudden && team == 1 && m_sd_rounds >= 4) g = !m_last_a;
      do_kick(team, g, ($urandom_range(0, 99) < noise_pct));
      guard++;
    end
    chk("game_done", done, 1);
    chk("game_no_grant", kick_en, 0);
    chk("game_winner", winner, m_win);
  endtask

  initial begin
    s_long   = '{1, 0, 1, 0, 1, 0};
    s_short  = '{1, 1, 1, 1, 1, 1, 1, 0};
    s_sudden = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    repeat (2) @(negedge clk);
    chk("rst_kick_en", kick_en, 0);
    chk("rst_turn", turn, 0);
    chk("rst_done", done, 0);
    chk("rst_sudden", sudden, 0);
    chk("rst_score_a", score_a, 0);
    chk("rst_round", round, 0);
    chk("rst_winner", winner, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_no_grant", kick_en, 0);

    // Both mode pulses: long series; a mode pulse in ARM_A is ignored.
    start_game(1, 1);
    mode_short = 1;
    @(negedge clk);
    mode_short = 0;
    chk("arm_mode_ignored", kick_en, 1);
    play(s_long, 0);
    chk("long_round", round, 3);

    start_game(0, 0);
    play(s_short, 0);
    chk("short_score_a", score_a, 4);
    chk("short_score_b", score_b, 3);

    start_game(0, 0);
    play(s_sudden, 0);
    chk("sudden_winner", winner, 2);
    chk("sudden_round", round, 5);

    start_game(0, 0);
    play(s_none, 100);

    // Enable low: a held kick pulse must not be granted.
    start_game(1, 0);
    en = 0;
    kick = 1;
    repeat (4) begin
      @(negedge clk);
      chk("en_low_hold", kick_en, 1);
    end
    kick = 0;
    en = 1;
    @(negedge clk);
    chk("en_resume_grant", kick_en, 1);
    chk("en_resume_turn", turn, 0);
    play(s_none, 30);

    // Asynchronous reset in the middle of WAIT_B.
    start_game(0, 0);
    do_kick(0, 1, 0);
    wait_grant(1);
    kick = 1;
    @(negedge clk);
    kick = 0;
    #2 rst = 0;
    #1;
    chk("arst_kick_en", kick_en, 0);
    chk("arst_turn", turn, 0);
    chk("arst_score_a", score_a, 0);
    chk("arst_round", round, 0);
    chk("arst_done", done, 0);
    chk("arst_winner", winner, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("arst_idle", kick_en, 0);

    for (int gme = 0; gme < 6; gme++) begin
      start_game(1'($urandom_range(0, 1)), 0);
      play(s_none, 25);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
